// File: rtl/aes_key_expansion.sv
// Iterative AES key schedule: one 32-bit word per cycle, 128-bit round-key reads.
// Optional KEYEXP_ZEROIZE_EN clears the word store on reset and hides it while keys are not valid.
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   localparam logic [2047:0] TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };
   assign y = TBL[2047 - 8*a -: 8];
endmodule

module aes_key_expansion #(
   parameter int MAXW = 60
) (
   input  logic         CLK,
   input  logic         RSTB,
   input  logic [255:0] CipherKey,
   input  logic [3:0]   Nk_val,
   input  logic         k_ready,
   input  logic         k_reset,
   input  logic [3:0]   rk_idx,
   output logic [127:0] rk_out,
   output logic         keys_valid,
   output logic         busy,
   output logic         key_err
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_EXP  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]   state_q, state_d;
   logic [3:0]   nk_q, nk_d;
   logic [3:0]   nr_q, nr_d;
   logic [5:0]   ntot_q, ntot_d;
   logic [5:0]   i_q, i_d;
   logic [2:0]   j_q, j_d;
   logic [7:0]   rcon_q, rcon_d;
   logic         keys_valid_q, keys_valid_d;
   logic         busy_q, busy_d;
   logic         key_err_q, key_err_d;
   logic [127:0] rk_q, rk_d;
   logic [31:0]  w_q [MAXW];

   logic         load_we, exp_we, nk_ok;
   logic [31:0]  prev_w, old_w, sub_in, sub_out, temp, new_w;
   logic [5:0]   r4;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   assign nk_ok  = (Nk_val == 4'd4) || (Nk_val == 4'd6) || (Nk_val == 4'd8);
   assign prev_w = w_q[i_q - 6'd1];
   assign old_w  = w_q[i_q - {2'b00, nk_q}];
   assign sub_in = (j_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (.a(sub_in[8*b +: 8]), .y(sub_out[8*b +: 8]));
   end

   always_comb begin
      temp = prev_w;
      if (j_q == 3'd0)
         temp = sub_out ^ {rcon_q, 24'h0};
      else if (nk_q == 4'd8 && j_q == 3'd4)
         temp = sub_out;
      new_w = old_w ^ temp;
   end

   always_comb begin
      state_d      = state_q;
      nk_d         = nk_q;
      nr_d         = nr_q;
      ntot_d       = ntot_q;
      i_d          = i_q;
      j_d          = j_q;
      rcon_d       = rcon_q;
      keys_valid_d = keys_valid_q;
      busy_d       = busy_q;
      key_err_d    = key_err_q;
      load_we      = 1'b0;
      exp_we       = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (state_q == S_DONE) begin
               busy_d       = 1'b0;
               keys_valid_d = 1'b1;
            end
            if (k_ready && nk_ok) begin
               nk_d         = Nk_val;
               nr_d         = Nk_val + 4'd6;
               ntot_d       = {Nk_val, 2'b00} + 6'd28;
               keys_valid_d = 1'b0;
               busy_d       = 1'b1;
               key_err_d    = 1'b0;
               state_d      = S_LOAD;
            end else if (k_ready) begin
               key_err_d    = 1'b1;
               keys_valid_d = 1'b0;
               busy_d       = 1'b0;
               state_d      = S_IDLE;
            end
         end
         S_LOAD: begin
            load_we = 1'b1;
            i_d     = {2'b00, nk_q};
            j_d     = 3'd0;
            rcon_d  = 8'h01;
            state_d = S_EXP;
         end
         S_EXP: begin
            exp_we = 1'b1;
            i_d    = i_q + 6'd1;
            j_d    = ({1'b0, j_q} == nk_q - 4'd1) ? 3'd0 : j_q + 3'd1;
            if (j_q == 3'd0)
               rcon_d = xtime(rcon_q);
            if (i_q == ntot_q - 6'd1)
               state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      if (k_reset) begin
         state_d      = S_IDLE;
         keys_valid_d = 1'b0;
         busy_d       = 1'b0;
         key_err_d    = 1'b0;
         load_we      = 1'b0;
         exp_we       = 1'b0;
      end
   end

   assign r4 = {rk_idx, 2'b00};

   always_comb begin
      rk_d = {w_q[r4], w_q[r4 + 6'd1], w_q[r4 + 6'd2], w_q[r4 + 6'd3]};
      if (rk_idx > nr_q)
         rk_d = '0;
`ifdef KEYEXP_ZEROIZE_EN
      if (!keys_valid_d)
         rk_d = '0;
`endif
      if (k_reset)
         rk_d = '0;
   end

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         state_q      <= S_IDLE;
         nk_q         <= 4'd4;
         nr_q         <= 4'd0;
         ntot_q       <= 6'd0;
         i_q          <= 6'd0;
         j_q          <= 3'd0;
         rcon_q       <= 8'h01;
         keys_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         key_err_q    <= 1'b0;
         rk_q         <= '0;
      end else begin
         state_q      <= state_d;
         nk_q         <= nk_d;
         nr_q         <= nr_d;
         ntot_q       <= ntot_d;
         i_q          <= i_d;
         j_q          <= j_d;
         rcon_q       <= rcon_d;
         keys_valid_q <= keys_valid_d;
         busy_q       <= busy_d;
         key_err_q    <= key_err_d;
         rk_q         <= rk_d;
      end
   end

`ifdef KEYEXP_ZEROIZE_EN
   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         for (int k = 0; k < MAXW; k++) w_q[k] <= '0;
      end else if (k_reset) begin
         for (int k = 0; k < MAXW; k++) w_q[k] <= '0;
      end else begin
         for (int k = 0; k < 8; k++)
            if (load_we && k < int'(nk_q))
               w_q[k] <= CipherKey[255 - 32*k -: 32];
         if (exp_we)
            w_q[i_q] <= new_w;
      end
   end
`else
   // Key material store is deliberately left without reset.
   always_ff @(posedge CLK) begin
      for (int k = 0; k < 8; k++)
         if (load_we && k < int'(nk_q))
            w_q[k] <= CipherKey[255 - 32*k -: 32];
      if (exp_we)
         w_q[i_q] <= new_w;
   end
`endif

   assign rk_out     = rk_q;
   assign keys_valid = keys_valid_q;
   assign busy       = busy_q;
   assign key_err    = key_err_q;
endmodule

// File: tb/tb_aes_key_expansion.sv
// Directed bench for aes_key_expansion: FIPS-197 schedules, latency,
// illegal key length, soft reset mid-expansion and restart from DONE.
module tb_aes_key_expansion;
   logic         CLK = 1'b0;
   logic         RSTB;
   logic [255:0] CipherKey;
   logic [3:0]   Nk_val;
   logic         k_ready;
   logic         k_reset;
   logic [3:0]   rk_idx;
   logic [127:0] rk_out;
   logic         keys_valid;
   logic         busy;
   logic         key_err;

   int checks = 0;
   int errors = 0;

   aes_key_expansion dut (
      .CLK(CLK), .RSTB(RSTB), .CipherKey(CipherKey), .Nk_val(Nk_val),
      .k_ready(k_ready), .k_reset(k_reset), .rk_idx(rk_idx),
      .rk_out(rk_out), .keys_valid(keys_valid), .busy(busy), .key_err(key_err)
   );

   always #5 CLK = ~CLK;

   localparam logic [255:0] K4 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K6 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] K8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   typedef struct {
      logic [3:0]   nk;
      logic [255:0] key;
      int           lat;
      logic [3:0]   idx;
      logic [127:0] exp_rk;
   } vec_t;

   vec_t tv[10];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp_v);
      end
   endtask

   task automatic start_key(input logic [3:0] nk, input logic [255:0] key);
      @(negedge CLK);
      Nk_val    = nk;
      CipherKey = key;
      k_ready   = 1'b1;
      @(negedge CLK);
      k_ready   = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (n < 200) begin
         @(posedge CLK);
         n++;
         #1;
         if (keys_valid) break;
      end
   endtask

   task automatic read_rk(input logic [3:0] idx, output logic [127:0] rk);
      @(negedge CLK);
      rk_idx = idx;
      @(posedge CLK);
      #1 rk = rk_out;
   endtask

   initial begin
      int n;
      logic [127:0] rk;

      tv[0] = '{4'd4, K4, 42, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
      tv[1] = '{4'd4, K4, 42, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      tv[2] = '{4'd4, K4, 42, 4'd11, 128'h0};
      tv[3] = '{4'd6, K6, 48, 4'd12, 128'he98ba06f448c773c8ecc720401002202};
      tv[4] = '{4'd6, K6, 48, 4'd13, 128'h0};
      tv[5] = '{4'd6, K6, 48, 4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5};
      tv[6] = '{4'd8, K8, 54, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781};
      tv[7] = '{4'd8, K8, 54, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e};
      tv[8] = '{4'd8, K8, 54, 4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde};
      tv[9] = '{4'd4, K4, 42, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f};

      RSTB = 1'b0; k_ready = 1'b0; k_reset = 1'b0;
      Nk_val = 4'd4; CipherKey = '0; rk_idx = 4'd0;
      repeat (3) @(negedge CLK);
      RSTB = 1'b1;
      @(negedge CLK);
      chk("rst_rk_out", rk_out, 128'h0);
      chk("rst_flags", {125'h0, keys_valid, busy, key_err}, 128'h0);

      for (int t = 0; t < 10; t++) begin
         start_key(tv[t].nk, tv[t].key);
         chk($sformatf("busy_%0d", t), {127'h0, busy}, 128'h1);
         wait_valid(n);
         chk($sformatf("latency_%0d", t), 128'(n), 128'(tv[t].lat));
         read_rk(tv[t].idx, rk);
         chk($sformatf("rk_%0d_idx%0d", t, tv[t].idx), rk, tv[t].exp_rk);
      end

      // illegal key length, then recovery
      start_key(4'd5, K4);
      chk("err_flags", {125'h0, key_err, busy, keys_valid}, {125'h0, 3'b100});
      repeat (2) @(negedge CLK);
      chk("err_idle", {126'h0, busy, keys_valid}, 128'h0);
      start_key(4'd4, K4);
      chk("err_cleared", {126'h0, key_err, busy}, 128'h1);
      wait_valid(n);
      chk("err_recover_lat", 128'(n), 128'd42);

      // soft reset mid-expansion together with k_ready
      start_key(4'd6, K6);
      repeat (19) @(negedge CLK);
      k_reset = 1'b1; k_ready = 1'b1; Nk_val = 4'd8; CipherKey = K8;
      @(negedge CLK);
      k_reset = 1'b0; k_ready = 1'b0;
      chk("krst_flags", {125'h0, busy, keys_valid, key_err}, 128'h0);
      chk("krst_rk_out", rk_out, 128'h0);
      repeat (3) @(negedge CLK);
      chk("krst_stay_idle", {126'h0, busy, keys_valid}, 128'h0);
      start_key(4'd4, K4);
      wait_valid(n);
      chk("krst_lat", 128'(n), 128'd42);
      read_rk(4'd10, rk);
      chk("krst_rk10", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // restart from DONE with a different key
      start_key(4'd8, K8);
      chk("restart_kv_drop", {127'h0, keys_valid}, 128'h0);
      read_rk(4'd0, rk);
`ifdef KEYEXP_ZEROIZE_EN
      chk("restart_gap_zero", rk, 128'h0);
`endif
      wait_valid(n);
      chk("restart_lat", 128'(n + 2), 128'd54);
      read_rk(4'd14, rk);
      chk("restart_rk14", rk, 128'hfe4890d1e6188d0b046df344706c631e);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/aes_key_expansion.md
Name: aes_key_expansion

Overview:
- Iterative AES key-schedule core. Sits directly downstream of the host I/O interface, which supplies CipherKey, Nk_val, k_ready and k_reset.
- Expands a 128/192/256-bit key into all round-key words, one word per cycle, and stores them internally.
- Serves 128-bit round keys by round index to the cipher core.
- Uses four instances of the team's combinational aes_sbox (8-bit forward S-box) for SubWord.

Parameters:
- MAXW, 60, depth of the 32-bit word store (4*(14+1)); do not change.

Ports:
- CLK  input  1  system clock
- RSTB  input  1  asynchronous active-low reset
- CipherKey  input  256  key, left-aligned: word0 = [255:224]; unused LSBs are 0
- Nk_val  input  4  key length in words: 4, 6 or 8
- k_ready  input  1  one-cycle pulse: CipherKey/Nk_val are valid, start expansion
- k_reset  input  1  synchronous soft reset of the core
- rk_idx  input  4  round index requested by the cipher core, 0..Nr
- rk_out  output  128  round key rk_idx, words w[4r]..w[4r+3], w[4r] in [127:96]
- keys_valid  output  1  all round keys for the current key are stored
- busy  output  1  expansion in progress
- key_err  output  1  last k_ready carried an illegal Nk_val

Behaviour:
- Reset (RSTB low, async) and k_reset (high, sync, dominates k_ready):
  - state=IDLE; keys_valid=0, busy=0, key_err=0, rk_out=0.
- FSM: IDLE -> LOAD -> EXPAND -> DONE.
  - IDLE/DONE + k_ready with Nk_val in {4,6,8}: latch Nk, Nr=Nk+6, Ntot=4*(Nr+1) (44/52/60); keys_valid<=0, busy<=1, key_err<=0; go LOAD.
  - IDLE/DONE + k_ready with any other Nk_val: key_err<=1, keys_valid<=0, stay/return IDLE.
  - LOAD (1 cycle): write w[0..Nk-1] from CipherKey in parallel; i<=Nk, j<=0 (j = i mod Nk), rcon<=8'h01; go EXPAND.
  - EXPAND: each cycle write w[i] = w[i-Nk] ^ temp, where temp is:
    - j==0: SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}, then rcon<=xtime(rcon);
    - Nk==8 and j==4: SubWord(w[i-1]);
    - otherwise: w[i-1].
    - Then i<=i+1; j wraps Nk-1 -> 0.
    - When i==Ntot-1 is written: go DONE, busy<=0, keys_valid<=1 on the next edge.
  - k_ready during LOAD/EXPAND is ignored (no queuing).
- Latency: k_ready at edge 0 -> keys_valid high after edge Ntot-Nk+2. That is 42/48/54 cycles for Nk=4/6/8.
- rk_out is registered: rk_idx sampled at edge n appears after edge n (1-cycle read latency).
  - rk_idx > Nr: rk_out = 0.
  - Reads are permitted at any time; while keys_valid=0 the content is undefined, except under the optional feature.
- A new k_ready in DONE restarts expansion and overwrites the store. keys_valid drops the cycle after that k_ready.
- Arithmetic: xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00). Rcon never exceeds 8'h36 for legal Nk.

Optional Feature:
- KEYEXP_ZEROIZE_EN defined:
  - RSTB and k_reset clear all MAXW words to 0.
  - rk_out is forced to 0 whenever keys_valid=0 (key-material zeroization).
- KEYEXP_ZEROIZE_EN undefined:
  - Word store has no reset.
  - rk_out reflects the store regardless of keys_valid.

Test Plan:
- Nk=4, key 2b7e151628aed2a6abf7158809cf4f3c, k_ready pulse -> keys_valid after 42 cycles; rk_idx=1 -> a0fafe1788542cb123a339392a6c7605; rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- Nk=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> keys_valid after 48 cycles; rk_idx=12 -> e98ba06f448c773c8ecc720401002202; rk_idx=13 -> 0.
- Nk=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> keys_valid after 54 cycles; rk_idx=0 -> 603deb1015ca71be2b73aef0857d7781; rk_idx=14 -> fe4890d1e6188d0b046df344706c631e.
- Nk_val=5 with k_ready -> key_err=1, busy stays 0, keys_valid=0. A following legal key then clears key_err.
- k_reset asserted mid-EXPAND (cycle 20) together with a k_ready -> next cycle IDLE, busy=0, keys_valid=0. A fresh Nk=4 run still yields the correct round-10 key.
- Second k_ready in DONE with a different key -> keys_valid falls the next cycle and re-rises with the new schedule. With KEYEXP_ZEROIZE_EN, rk_out reads 0 during the gap.
